scan_decoder: RTL and testbench
===============================

Name: scan_decoder

Overview:
- Parametrised, registered N-to-2^N one-hot decoder with an active-level select and enable.
- Adds an autonomous scan mode: an internal dwell/blank sequencer cycles through NUM_CH channels.
- Drives digit or row selects of multiplexed 7-segment and LED-matrix displays.
- Manual mode gives a registered direct decode of sel, replacing the hand-written combinational decoders.

Parameters:
- SEL_W, 3: select width; output width is 2**SEL_W.
- NUM_CH, 8: channels visited in scan mode. Legal range 1..2**SEL_W. sel values at or above NUM_CH decode to all-inactive.
- DWELL, 1000: clock cycles a channel stays asserted in scan mode. Must be at least 1.
- BLANK, 2: all-inactive cycles inserted between channels in scan mode. 0 means no gap.
- ACTIVE_LOW, 1: 1 means the asserted output bit is 0 and idle is all-ones. 0 means one-hot high, idle all-zeros.

Ports:
- clk, in, 1: system clock, rising edge.
- rst, in, 1: asynchronous, active-high reset.
- en, in, 1: enable. Low forces all outputs inactive.
- mode, in, 1: 0 = manual decode of sel, 1 = auto scan.
- sel, in, SEL_W: channel select used in manual mode.
- y, out, 2**SEL_W: registered one-hot select output, polarity set by ACTIVE_LOW.
- idx, out, SEL_W: index of the channel currently selected or last selected.
- wrap, out, 1: one-cycle pulse when the scan returns to channel 0.

Behaviour:
- Reset (asynchronous assert; release synchronous to clk):
  - y = IDLE_PAT (all ones if ACTIVE_LOW, else all zeros).
  - idx = 0, wrap = 0, dwell/blank counter = 0, state = IDLE.
- All outputs are registered. Inputs sampled at edge k appear on the outputs after edge k, i.e. 1-cycle latency.
- States:
  - IDLE: entered when en=0 or after reset.
  - MANUAL: entered when en=1 and mode=0.
  - DWELL and GAP: used when en=1 and mode=1.
- IDLE:
  - y = IDLE_PAT, counter held at 0, idx unchanged.
  - en=1 moves to MANUAL or DWELL according to mode.
- MANUAL:
  - Each cycle, y <= decode(sel) and idx <= sel.
  - If sel >= NUM_CH, y <= IDLE_PAT and idx <= sel.
  - No blanking is applied in manual mode. wrap = 0.
- Scan entry (from IDLE or MANUAL):
  - idx <= 0, counter <= 0, y <= decode(0), state DWELL.
  - wrap is not pulsed on entry.
- DWELL:
  - y holds decode(idx) for exactly DWELL cycles.
  - On the last dwell cycle, go to GAP if BLANK > 0 (y <= IDLE_PAT). Otherwise advance directly.
- GAP:
  - y = IDLE_PAT for exactly BLANK cycles, then advance.
- Advance:
  - idx <= (idx == NUM_CH-1) ? 0 : idx+1, and y <= decode of the new idx in the same edge.
  - wrap = 1 for the single cycle in which the new idx 0 is first presented.
- NUM_CH = 1: idx stays 0. The output pulses per DWELL/BLANK, and wrap pulses on every advance.
- Frame period: NUM_CH * (DWELL + BLANK) cycles.
- Mid-operation changes:
  - mode 1->0: MANUAL takes effect at the next edge; the counter is cleared.
  - mode 0->1: restarts the scan at idx 0.
  - en falling: y = IDLE_PAT at the next edge.
  - en rising with mode=1: restarts at idx 0.
- Counter width: $clog2(max(DWELL, BLANK) + 1). The counter never exceeds max(DWELL, BLANK) - 1.
- Simultaneous events: rst overrides all; en=0 overrides mode.

Decomposition:
- Package scan_decoder_pkg holds:
  - state enum (IDLE, MANUAL, DWELL, GAP);
  - MODE_MANUAL / MODE_SCAN constants;
  - function idle_pat(width, active_low).
- Sub-module onehot_decode: purely combinational, parameters SEL_W, NUM_CH, ACTIVE_LOW.
  - Inputs: code, valid. Output: pattern.
  - Instantiated once, feeding the y register.
- The sequencer (FSM plus counter) stays in scan_decoder.

Test Plan:
- Reset behaviour: SEL_W=3, ACTIVE_LOW=1. Assert rst mid-scan -> y=8'hFF, idx=0, wrap=0 immediately, without waiting for a clock. Release -> IDLE, y stays 8'hFF while en=0.
- Manual decode: en=1, mode=0, NUM_CH=6. Sweep sel 0..7 -> one cycle later y = FE, FD, FB, F7, EF, DF, then FF, FF for sel 6 and 7; idx tracks sel.
- Scan timing: DWELL=4, BLANK=1, NUM_CH=6, en=1, mode=1 -> y=FE for 4 cycles, FF for 1, FD for 4 ... DF for 4, FF for 1, then FE. wrap=1 only on that first FE cycle; frame period = 30 cycles.
- Zero blanking: BLANK=0, DWELL=2, NUM_CH=3 -> y sequence FE, FE, FD, FD, FB, FB, FE ... with no FF gap.
- Mode/enable interruption: switch mode to 0 with sel=2 while scanning at idx=4 -> next cycle y=FB, idx=2. Return to mode=1 -> idx=0, y=FE, full DWELL. Drop en for 1 cycle -> y=FF, then scan restarts at idx 0.
- Polarity and edge case: ACTIVE_LOW=0, NUM_CH=1, DWELL=3, BLANK=2 -> y = 01 for 3 cycles, 00 for 2 cycles, repeating. wrap pulses each time 01 reappears.

Source files
------------

// File: rtl/scan_decoder_pkg.sv
// Shared types and helpers for the scan_decoder display-select block.
package scan_decoder_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_MANUAL,
    S_DWELL,
    S_GAP
  } state_t;

  localparam logic MODE_MANUAL = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;

  // Inactive output pattern, LSB-aligned; callers truncate to their width (<= 64).
  function automatic logic [63:0] idle_pat(input int width, input bit active_low);
    logic [63:0] p;
    p = '0;
    for (int i = 0; i < 64; i++) begin
      if (active_low && (i < width)) p[i] = 1'b1;
    end
    return p;
  endfunction

endpackage

// File: rtl/scan_decoder_onehot_decode.sv
// Combinational one-hot decoder; codes at or above NUM_CH, or valid low, give the idle pattern.
module onehot_decode
  import scan_decoder_pkg::*;
#(
  parameter int SEL_W      = 3,
  parameter int NUM_CH     = 8,
  parameter int ACTIVE_LOW = 1
) (
  input  logic [SEL_W-1:0]      code,
  input  logic                  valid,
  output logic [2**SEL_W-1:0]   pattern
);

  localparam int OUT_W = 2**SEL_W;
  localparam logic [OUT_W-1:0] IDLE_PAT = OUT_W'(idle_pat(OUT_W, ACTIVE_LOW != 0));
  localparam logic [SEL_W:0]   NCH      = (SEL_W+1)'(NUM_CH);

  logic [OUT_W-1:0] hot;

  always_comb begin
    hot = OUT_W'(1) << code;
    if (valid && ({1'b0, code} < NCH)) begin
      pattern = (ACTIVE_LOW != 0) ? ~hot : hot;
    end else begin
      pattern = IDLE_PAT;
    end
  end

endmodule

// File: rtl/scan_decoder.sv
// Registered N-to-2^N select decoder with manual decode and an autonomous dwell/blank scan sequencer.
module scan_decoder
  import scan_decoder_pkg::*;
#(
  parameter int SEL_W      = 3,
  parameter int NUM_CH     = 8,
  parameter int DWELL      = 1000,
  parameter int BLANK      = 2,
  parameter int ACTIVE_LOW = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  mode,
  input  logic [SEL_W-1:0]      sel,
  output logic [2**SEL_W-1:0]   y,
  output logic [SEL_W-1:0]      idx,
  output logic                  wrap
);

  localparam int OUT_W   = 2**SEL_W;
  localparam int CNT_MAX = (DWELL > BLANK) ? DWELL : BLANK;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [OUT_W-1:0] IDLE_PAT  = OUT_W'(idle_pat(OUT_W, ACTIVE_LOW != 0));
  localparam logic [SEL_W-1:0] LAST_CH   = SEL_W'(NUM_CH - 1);
  localparam logic [CNT_W-1:0] DWELL_END = CNT_W'(DWELL - 1);
  localparam logic [CNT_W-1:0] GAP_END   = CNT_W'((BLANK > 0) ? BLANK - 1 : 0);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [SEL_W-1:0] idx_next;
  logic [SEL_W-1:0] dec_code;
  logic             dec_valid;
  logic [OUT_W-1:0] dec_pat;
  logic             scanning;
  logic             dwell_done;
  logic             gap_done;

  assign idx_next   = (idx == LAST_CH) ? '0 : idx + 1'b1;
  assign scanning   = (state == S_DWELL) || (state == S_GAP);
  assign dwell_done = (cnt == DWELL_END);
  assign gap_done   = (cnt == GAP_END);

  // Select what the single decoder presents to the y register at the next edge.
  always_comb begin
    dec_code  = '0;
    dec_valid = 1'b0;
    if (en) begin
      if (mode == MODE_MANUAL) begin
        dec_code  = sel;
        dec_valid = 1'b1;
      end else if (!scanning) begin
        dec_code  = '0;
        dec_valid = 1'b1;
      end else if (state == S_DWELL) begin
        if (!dwell_done) begin
          dec_code  = idx;
          dec_valid = 1'b1;
        end else if (BLANK == 0) begin
          dec_code  = idx_next;
          dec_valid = 1'b1;
        end
      end else if (gap_done) begin
        dec_code  = idx_next;
        dec_valid = 1'b1;
      end
    end
  end

  onehot_decode #(
    .SEL_W      (SEL_W),
    .NUM_CH     (NUM_CH),
    .ACTIVE_LOW (ACTIVE_LOW)
  ) u_dec (
    .code    (dec_code),
    .valid   (dec_valid),
    .pattern (dec_pat)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
      cnt   <= '0;
      idx   <= '0;
      y     <= IDLE_PAT;
      wrap  <= 1'b0;
    end else begin
      y    <= dec_pat;
      wrap <= 1'b0;
      if (!en) begin
        state <= S_IDLE;
        cnt   <= '0;
      end else if (mode == MODE_MANUAL) begin
        state <= S_MANUAL;
        cnt   <= '0;
        idx   <= sel;
      end else if (!scanning) begin
        state <= S_DWELL;
        cnt   <= '0;
        idx   <= '0;
      end else if (state == S_DWELL) begin
        if (!dwell_done) begin
          cnt <= cnt + 1'b1;
        end else if (BLANK > 0) begin
          state <= S_GAP;
          cnt   <= '0;
        end else begin
          cnt  <= '0;
          idx  <= idx_next;
          wrap <= (idx_next == '0);
        end
      end else begin
        if (!gap_done) begin
          cnt <= cnt + 1'b1;
        end else begin
          state <= S_DWELL;
          cnt   <= '0;
          idx   <= idx_next;
          wrap  <= (idx_next == '0);
        end
      end
    end
  end

endmodule

// File: tb/tb_scan_decoder.sv
// Bench for scan_decoder: three configurations share one random stimulus stream, checked against a time-based model.
module tb_scan_decoder;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic       mode = 1'b0;
  logic [2:0] sel = 3'd0;

  logic [7:0] y_o [3];
  logic [2:0] i_o [3];
  logic       w_o [3];

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  // A: NUM_CH=6, DWELL=4, BLANK=1, active low
  scan_decoder #(.SEL_W(3), .NUM_CH(6), .DWELL(4), .BLANK(1), .ACTIVE_LOW(1)) u_a (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .sel(sel),
    .y(y_o[0]), .idx(i_o[0]), .wrap(w_o[0]));
  // B: NUM_CH=3, DWELL=2, no blanking
  scan_decoder #(.SEL_W(3), .NUM_CH(3), .DWELL(2), .BLANK(0), .ACTIVE_LOW(1)) u_b (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .sel(sel),
    .y(y_o[1]), .idx(i_o[1]), .wrap(w_o[1]));
  // C: single channel, active high
  scan_decoder #(.SEL_W(3), .NUM_CH(1), .DWELL(3), .BLANK(2), .ACTIVE_LOW(0)) u_c (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .sel(sel),
    .y(y_o[2]), .idx(i_o[2]), .wrap(w_o[2]));

  int nch [3] = '{6, 3, 1};
  int dwl [3] = '{4, 2, 3};
  int blk [3] = '{1, 0, 2};
  int alo [3] = '{1, 1, 0};

  bit         scn [3];
  int         tsc [3];
  logic [7:0] ey [3];
  logic [2:0] ei [3];
  logic       ew [3];

  function automatic logic [7:0] mdec(input int c, input int al);
    logic [7:0] v;
    v = 8'd1 << c;
    return (al != 0) ? ~v : v;
  endfunction

  function automatic logic [7:0] midle(input int al);
    return (al != 0) ? 8'hFF : 8'h00;
  endfunction

  // Reference: scan output is a function of cycles elapsed since scan entry.
  always @(posedge clk or posedge rst) begin
    for (int i = 0; i < 3; i++) begin
      if (rst) begin
        scn[i] = 1'b0;
        ey[i]  = midle(alo[i]);
        ei[i]  = 3'd0;
        ew[i]  = 1'b0;
      end else if (!en) begin
        scn[i] = 1'b0;
        ey[i]  = midle(alo[i]);
        ew[i]  = 1'b0;
      end else if (!mode) begin
        scn[i] = 1'b0;
        ei[i]  = sel;
        ey[i]  = (int'(sel) < nch[i]) ? mdec(int'(sel), alo[i]) : midle(alo[i]);
        ew[i]  = 1'b0;
      end else begin
        int per, ch, ph;
        if (!scn[i]) begin
          scn[i] = 1'b1;
          tsc[i] = 0;
        end else begin
          tsc[i] = tsc[i] + 1;
        end
        per   = dwl[i] + blk[i];
        ch    = (tsc[i] / per) % nch[i];
        ph    = tsc[i] % per;
        ei[i] = 3'(ch);
        ey[i] = (ph < dwl[i]) ? mdec(ch, alo[i]) : midle(alo[i]);
        ew[i] = (tsc[i] > 0) && (tsc[i] % (nch[i] * per) == 0);
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s t=%0t got=%0h exp=%0h", tag, $time, got, exp);
    end
  endtask

  task automatic check_all();
    string nm [3] = '{"a", "b", "c"};
    for (int i = 0; i < 3; i++) begin
      chk({"y_", nm[i]}, 32'(y_o[i]), 32'(ey[i]));
      chk({"idx_", nm[i]}, 32'(i_o[i]), 32'(ei[i]));
      chk({"wrap_", nm[i]}, 32'(w_o[i]), 32'(ew[i]));
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(negedge clk);
      check_all();
    end
  endtask

  initial begin
    // reset and idle
    cyc(3);
    rst = 1'b0;
    cyc(3);

    // manual sweep
    en = 1'b1;
    mode = 1'b0;
    for (int s = 0; s < 8; s++) begin
      sel = 3'(s);
      cyc(1);
    end

    // free-running scan over more than two frames of A
    mode = 1'b1;
    cyc(70);

    // seek A to channel 4, then interrupt into manual
    for (int k = 0; k < 60 && ei[0] != 3'd4; k++) cyc(1);
    chk("seek_a_idx4", 32'(i_o[0]), 32'd4);
    mode = 1'b0;
    sel = 3'd2;
    cyc(3);
    mode = 1'b1;
    cyc(12);
    en = 1'b0;
    cyc(1);
    en = 1'b1;
    cyc(12);

    // randomized segments
    for (int seg = 0; seg < 30; seg++) begin
      en   = ($urandom_range(0, 7) != 0);
      mode = ($urandom_range(0, 2) != 0);
      sel  = 3'($urandom_range(0, 7));
      cyc($urandom_range(1, 40));
    end

    // asynchronous reset mid-scan
    en = 1'b1;
    mode = 1'b1;
    cyc(9);
    #2 rst = 1'b1;
    #1;
    chk("arst_y_a", 32'(y_o[0]), 32'hFF);
    chk("arst_idx_a", 32'(i_o[0]), 32'd0);
    chk("arst_wrap_a", 32'(w_o[0]), 32'd0);
    chk("arst_y_c", 32'(y_o[2]), 32'h00);
    en = 1'b0;
    cyc(2);
    rst = 1'b0;
    cyc(4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
